regfile_write_scheduler: RTL

Sequences the single register-file write port between three requesters: the pipeline WB stage, the multi-cycle multiply/divide unit (MD), and the debug write port (DBG). Holds MD results in a small queue until a WB-idle slot opens. Keeps a pending-destination scoreboard so the hazard unit can stall ID on RAW/WAW against outstanding MD results. Sits between MEM/WB, the MD unit and the register file write inputs.

---
 rtl/regfile_write_scheduler.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates the single register-file write port between WB, queued MD results and debug writes.
// Ports: WB_* write-back request; MD_Issue/MD_IssueDst set the pending scoreboard;
// MD_Valid/MD_Ready/MD_Dst/MD_Data feed the MD result queue; DBG_* debug write with Ack pulse;
// ID_* operands checked against pending MD results -> ID_Stall; Force_Bubble asks for a WB bubble
// when the queue starves; RF_* registered write port (one cycle after the grant).
module regfile_write_scheduler #(
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_RegWrite,
  input  logic        WB_JmpandLink,
  input  logic [4:0]  WB_DstReg,
  input  logic [31:0] WB_Data,
  input  logic        MD_Issue,
  input  logic [4:0]  MD_IssueDst,
  input  logic        MD_Valid,
  output logic        MD_Ready,
  input  logic [4:0]  MD_Dst,
  input  logic [31:0] MD_Data,
  input  logic        DBG_Req,
  input  logic [4:0]  DBG_Addr,
  input  logic [31:0] DBG_Data,
  output logic        DBG_Ack,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic [4:0]  ID_Dst,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_Writes,
  output logic        ID_Stall,
  output logic        Force_Bubble,
  output logic        RF_WrEn,
  output logic [4:0]  RF_WrAddr,
  output logic [31:0] RF_WrData
);
  localparam int AW = $clog2(QDEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]    qdst_q [QDEPTH];
  logic [31:0]   qdat_q [QDEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          en_q, en_d, ack_q, ack_d;
  logic [4:0]    addr_q, addr_d, wb_addr, head_dst;
  logic [31:0]   data_q, data_d, head_dat;
  logic          wb_v, empty, md_gnt, dbg_gnt, push;
  always_comb begin
    wb_addr  = WB_JmpandLink ? 5'd31 : WB_DstReg;
    wb_v     = WB_RegWrite && (WB_JmpandLink || wb_addr != 5'd0);
    empty    = cnt_q == '0;
    MD_Ready = cnt_q != (AW+1)'(QDEPTH);
    head_dst = qdst_q[rd_q];
    head_dat = qdat_q[rd_q];
    md_gnt   = !empty && !wb_v;
    // ack_q blocks a second grant while the held request is still visible in the ack cycle
    dbg_gnt  = DBG_Req && !wb_v && empty && !ack_q;
    push     = MD_Valid && MD_Ready && MD_Dst != 5'd0;
    en_d     = wb_v || md_gnt || (dbg_gnt && DBG_Addr != 5'd0);
    addr_d   = wb_v ? wb_addr : md_gnt ? head_dst : en_d ? DBG_Addr : 5'd0;
    data_d   = wb_v ? WB_Data : md_gnt ? head_dat : en_d ? DBG_Data : 32'd0;
    ack_d    = dbg_gnt;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(md_gnt);
    // set after clear so a same-cycle issue to the retiring register stays pending
    pend_d   = ((pend_q & ~(md_gnt ? 32'd1 << head_dst : 32'd0))
               | (MD_Issue ? 32'd1 << MD_IssueDst : 32'd0)) & ~32'd1;
    starve_d = (empty || md_gnt) ? '0 :
               (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
  end
  assign ID_Stall     = (ID_UsesRs && pend_q[ID_Rs]) || (ID_UsesRt && pend_q[ID_Rt]) ||
                        (ID_Writes && pend_q[ID_Dst]);
  assign Force_Bubble = starve_q >= SW'(STARVE_LIMIT);
  assign RF_WrEn      = en_q;
  assign RF_WrAddr    = addr_q;
  assign RF_WrData    = data_q;
  assign DBG_Ack      = ack_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      starve_q <= '0;
    end else begin
      en_q     <= en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      rd_q     <= rd_q + AW'(md_gnt);
      wr_q     <= wr_q + AW'(push);
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      qdst_q[wr_q] <= MD_Dst;
      qdat_q[wr_q] <= MD_Data;
    end
  end
endmodule
